// File: rtl/blake2s_block_feeder_pkg.sv
// Shared constants and FSM state type for the BLAKE2s block feeder.
package blake2s_block_feeder_pkg;

  localparam int BLOCK_BYTES = 64;  // message block size; only 64 is supported
  localparam int IDX_W       = 6;   // byte index within a block
  localparam int LL_W        = 64;  // running message byte count

  typedef enum logic [1:0] {
    ST_FILL = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } state_t;

endpackage

// File: rtl/blake2s_block_ram.sv
// 64x8 block buffer: one synchronous write port, one combinational read port.
module blake2s_block_ram
  import blake2s_block_feeder_pkg::*;
#(
  parameter int DEPTH = BLOCK_BYTES
) (
  input  logic             clk,
  input  logic             we,
  input  logic [IDX_W-1:0] waddr,
  input  logic [7:0]       wdata,
  input  logic [IDX_W-1:0] raddr,
  output logic [7:0]       rdata
);

  logic [7:0] mem [DEPTH];

  // Byte write on the rising edge.
  // NOTE: the storage array has no reset; stale bytes beyond fill_cnt are masked by the padding logic downstream.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/blake2s_block_feeder.sv
// Collects message bytes into 64-byte blocks, zero-pads the final block and
// streams each block to the hash core with first/last flags and byte count.
module blake2s_block_feeder #(
  parameter int BLOCK_BYTES = blake2s_block_feeder_pkg::BLOCK_BYTES
) (
  input  logic        clk,
  input  logic        nreset,
  input  logic        valid_i,
  input  logic [7:0]  data_i,
  input  logic        last_i,
  input  logic        empty_i,
  output logic        ready_o,
  input  logic        core_ready_i,
  output logic        data_v_o,
  output logic [7:0]  data_o,
  output logic [5:0]  data_idx_o,
  output logic        block_first_o,
  output logic        block_last_o,
  output logic [63:0] ll_o,
  output logic        busy_o
);

  import blake2s_block_feeder_pkg::*;

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(BLOCK_BYTES - 1);

  state_t           state;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] send_idx;
  logic [IDX_W:0]   fill_cnt;    // 0..64 valid bytes in the current block
  logic             first_pend;
  logic             last_pend;
  logic [LL_W-1:0]  ll;
  logic [7:0]       rd_byte;

  logic accept;
  logic new_msg;
  logic in_send;

  assign ready_o = (state == ST_FILL);
  assign accept  = valid_i && ready_o;
  assign in_send = (state == ST_SEND);
  // A message starts when nothing has been buffered yet and the previous block closed a message.
  assign new_msg = first_pend && (wr_idx == '0);

  blake2s_block_ram #(
    .DEPTH (BLOCK_BYTES)
  ) u_ram (
    .clk   (clk),
    .we    (accept),
    .waddr (wr_idx),
    .wdata (data_i),
    .raddr (send_idx),
    .rdata (rd_byte)
  );

  // Fill / wait / send sequencing, buffer pointers and message byte count.
  // NOTE: all state here uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state      <= ST_FILL;
      wr_idx     <= '0;
      send_idx   <= '0;
      fill_cnt   <= '0;
      first_pend <= 1'b1;
      last_pend  <= 1'b0;
      ll         <= '0;
    end else begin
      case (state)
        ST_FILL: begin
          if (accept) begin
            wr_idx <= wr_idx + 1'b1;
            ll     <= new_msg ? LL_W'(1) : ll + LL_W'(1);
            if (last_i || (wr_idx == IDX_MAX)) begin
              state     <= ST_WAIT;
              fill_cnt  <= {1'b0, wr_idx} + 1'b1;
              last_pend <= last_i;
            end
          end else if (empty_i && new_msg) begin
            // Zero-length message: one all-padding block that is both first and last.
            state     <= ST_WAIT;
            fill_cnt  <= '0;
            last_pend <= 1'b1;
            ll        <= '0;
          end
        end
        ST_WAIT: begin
          if (core_ready_i) begin
            state    <= ST_SEND;
            send_idx <= '0;
          end
        end
        ST_SEND: begin
          send_idx <= send_idx + 1'b1;
          if (send_idx == IDX_MAX) begin
            state      <= ST_FILL;
            wr_idx     <= '0;
            first_pend <= last_pend;
          end
        end
        default: state <= ST_FILL;
      endcase
    end
  end

  assign data_v_o      = in_send;
  assign data_idx_o    = send_idx;
  assign data_o        = (in_send && ({1'b0, send_idx} < fill_cnt)) ? rd_byte : 8'h00;
  assign block_first_o = in_send && first_pend;
  assign block_last_o  = in_send && last_pend;
  assign ll_o          = ll;
  assign busy_o        = (state == ST_WAIT) || in_send;

endmodule

// File: tb/tb_blake2s_block_feeder.sv
// Scoreboard bench for the BLAKE2s block feeder: drivers push expected block
// bytes computed from whole messages; a monitor pops and compares on data_v_o.
module tb_blake2s_block_feeder;

  logic        clk = 1'b0;
  logic        nreset;
  logic        valid_i, last_i, empty_i, core_ready_i;
  logic [7:0]  data_i;
  logic        ready_o, data_v_o, block_first_o, block_last_o, busy_o;
  logic [7:0]  data_o;
  logic [5:0]  data_idx_o;
  logic [63:0] ll_o;

  typedef struct {
    logic [7:0]  d;
    logic [5:0]  idx;
    logic        f;
    logic        l;
    logic [63:0] ll;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       e;
  logic [7:0] msg_q[$];
  int         total = 0;
  int         bad   = 0;
  bit         cr_rand = 1'b0;

  blake2s_block_feeder dut (
    .clk           (clk),
    .nreset        (nreset),
    .valid_i       (valid_i),
    .data_i        (data_i),
    .last_i        (last_i),
    .empty_i       (empty_i),
    .ready_o       (ready_o),
    .core_ready_i  (core_ready_i),
    .data_v_o      (data_v_o),
    .data_o        (data_o),
    .data_idx_o    (data_idx_o),
    .block_first_o (block_first_o),
    .block_last_o  (block_last_o),
    .ll_o          (ll_o),
    .busy_o        (busy_o)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: split the message into 64-byte blocks, zero-pad the tail,
  // flag first/last blocks; the byte count seen during a block is the bytes fed so far.
  task automatic push_expected(input int n);
    int nblk;
    exp_t x;
    nblk = (n == 0) ? 1 : (n + 63) / 64;
    for (int b = 0; b < nblk; b++) begin
      for (int i = 0; i < 64; i++) begin
        int pos;
        pos   = b * 64 + i;
        x.d   = (pos < n) ? msg_q[pos] : 8'h00;
        x.idx = 6'(i);
        x.f   = (b == 0);
        x.l   = (b == nblk - 1);
        x.ll  = (b == nblk - 1) ? 64'(n) : 64'((b + 1) * 64);
        exp_q.push_back(x);
      end
    end
  endtask

  // Monitor: compare every emitted byte against the scoreboard head.
  always @(negedge clk) begin
    if (data_v_o) begin
      if (exp_q.size() == 0) begin
        check("spurious_data_v", 64'(data_v_o), 64'd0);
      end else begin
        e = exp_q.pop_front();
        check("data",          64'(data_o),        64'(e.d));
        check("data_idx",      64'(data_idx_o),    64'(e.idx));
        check("block_first",   64'(block_first_o), 64'(e.f));
        check("block_last",    64'(block_last_o),  64'(e.l));
        check("ll_in_send",    ll_o,               e.ll);
        check("ready_in_send", 64'(ready_o),       64'd0);
      end
    end else begin
      check("idle_outputs", 64'({data_o, data_idx_o, block_first_o, block_last_o}), 64'd0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (cr_rand) core_ready_i = ($urandom_range(0, 3) != 0);
  endtask

  task automatic do_reset();
    nreset  = 1'b0;
    valid_i = 1'b0;
    last_i  = 1'b0;
    empty_i = 1'b0;
    data_i  = 8'h00;
    exp_q.delete();
    step();
    step();
    nreset = 1'b1;
  endtask

  task automatic fill_msg(input int n);
    msg_q.delete();
    for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 255)));
  endtask

  // Feed msg_q byte by byte; returns in the cycle after the final byte is accepted.
  task automatic send_msg(input int n, input bit gaps, input bit empty_on_first);
    for (int i = 0; i < n; i++) begin
      int cnt;
      if (gaps && $urandom_range(0, 3) == 0) begin
        valid_i = 1'b0;
        last_i  = 1'($urandom_range(0, 1));          // stray last without valid
        empty_i = (i > 0) && ($urandom_range(0, 1) == 1); // mid-message empty request
        step();
      end
      valid_i = 1'b1;
      data_i  = msg_q[i];
      last_i  = (i == n - 1);
      empty_i = empty_on_first && (i == 0);
      cnt = 0;
      while (!ready_o && cnt < 2000) begin
        step();
        cnt++;
      end
      if (cnt >= 2000) check("ready_timeout", 64'(ready_o), 64'd1);
      step();
    end
    valid_i = 1'b0;
    last_i  = 1'b0;
    empty_i = 1'b0;
  endtask

  task automatic wait_idle();
    int cnt;
    cnt = 0;
    while ((busy_o || exp_q.size() != 0) && cnt < 3000) begin
      step();
      cnt++;
    end
    check("idle_busy",     64'(busy_o),       64'd0);
    check("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    int cnt;
    nreset       = 1'b0;
    core_ready_i = 1'b1;
    do_reset();

    // Reset state
    check("rst_ready", 64'(ready_o),  64'd1);
    check("rst_busy",  64'(busy_o),   64'd0);
    check("rst_v",     64'(data_v_o), 64'd0);
    check("rst_ll",    ll_o,          64'd0);

    // "abc" with minimum latency
    msg_q = '{8'h61, 8'h62, 8'h63};
    push_expected(3);
    send_msg(3, 1'b0, 1'b0);
    check("lat_busy", 64'(busy_o),   64'd1);
    check("lat_v_n1", 64'(data_v_o), 64'd0);
    step();
    check("lat_v_n2", 64'(data_v_o), 64'd1);
    wait_idle();
    check("abc_ll_hold", ll_o, 64'd3);

    // Exactly 64 bytes, then 65 bytes
    fill_msg(64);
    push_expected(64);
    send_msg(64, 1'b0, 1'b0);
    wait_idle();
    check("ll64_hold", ll_o, 64'd64);
    fill_msg(65);
    push_expected(65);
    send_msg(65, 1'b0, 1'b0);
    wait_idle();
    check("ll65_hold", ll_o, 64'd65);

    // Empty message after reset, then empty_i together with valid_i
    do_reset();
    msg_q.delete();
    push_expected(0);
    empty_i = 1'b1;
    step();
    empty_i = 1'b0;
    wait_idle();
    check("empty_ll", ll_o, 64'd0);
    fill_msg(1);
    push_expected(1);
    send_msg(1, 1'b0, 1'b1);
    wait_idle();
    check("empty_with_valid_ll", ll_o, 64'd1);

    // Core stalls for 10 cycles after fill
    core_ready_i = 1'b0;
    fill_msg(5);
    push_expected(5);
    send_msg(5, 1'b0, 1'b0);
    for (int k = 0; k < 10; k++) begin
      check("stall_busy",  64'(busy_o),   64'd1);
      check("stall_v",     64'(data_v_o), 64'd0);
      check("stall_ready", 64'(ready_o),  64'd0);
      step();
    end
    core_ready_i = 1'b1;
    step();
    check("stall_release_v", 64'(data_v_o), 64'd1);
    wait_idle();

    // Reset in the middle of a burst
    fill_msg(10);
    push_expected(10);
    send_msg(10, 1'b0, 1'b0);
    cnt = 0;
    while (!(data_v_o && data_idx_o == 6'd20) && cnt < 200) begin
      step();
      cnt++;
    end
    check("reached_idx20", 64'(data_idx_o), 64'd20);
    nreset = 1'b0;
    exp_q.delete();
    #1;
    check("abort_v",     64'(data_v_o), 64'd0);
    check("abort_ready", 64'(ready_o),  64'd1);
    check("abort_ll",    ll_o,          64'd0);
    do_reset();
    msg_q = '{8'h61, 8'h62, 8'h63};
    push_expected(3);
    send_msg(3, 1'b0, 1'b0);
    wait_idle();

    // Randomized messages with input gaps and a wandering core_ready_i
    cr_rand = 1'b1;
    for (int m = 0; m < 8; m++) begin
      int n;
      n = $urandom_range(1, 140);
      fill_msg(n);
      push_expected(n);
      send_msg(n, 1'b1, 1'b0);
      wait_idle();
      check("rand_ll_hold", ll_o, 64'(n));
    end
    cr_rand = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
